// File: rtl/ddr_train_pkg.sv
// Shared types and helpers for the DDR read-eye training controller.
package ddr_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_STEP,
    ST_CENTER,
    ST_NEXT,
    ST_DONE
  } train_state_e;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  function automatic int tap_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/ddr_eye_window_tracker.sv
// Tracks the first contiguous run of passing taps during a sweep and
// reports whether it forms a usable eye plus its floor-centre tap.
module ddr_eye_window_tracker #(
  parameter int TAP_W   = 7,
  parameter int MIN_EYE = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             sample_i,
  input  logic             pass_i,
  input  logic [TAP_W-1:0] tap_i,
  output logic             open_o,
  output logic             valid_o,
  output logic [TAP_W-1:0] center_o
);

  logic             found_q, found_d;
  logic             closed_q, closed_d;
  logic [TAP_W-1:0] start_q, start_d;
  logic [TAP_W-1:0] end_q, end_d;
  logic [TAP_W:0]   eye_w;
  logic [TAP_W:0]   tap_sum;

  always_comb begin
    found_d  = found_q;
    closed_d = closed_q;
    start_d  = start_q;
    end_d    = end_q;
    if (clear_i) begin
      found_d  = 1'b0;
      closed_d = 1'b0;
      start_d  = '0;
      end_d    = '0;
    end else if (sample_i && !closed_q) begin
      if (pass_i) begin
        if (!found_q) begin
          found_d = 1'b1;
          start_d = tap_i;
        end
        end_d = tap_i;
      end else if (found_q) begin
        closed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      found_q  <= 1'b0;
      closed_q <= 1'b0;
      start_q  <= '0;
      end_q    <= '0;
    end else begin
      found_q  <= found_d;
      closed_q <= closed_d;
      start_q  <= start_d;
      end_q    <= end_d;
    end
  end

  // One extra bit so start+end cannot wrap before the halving.
  assign eye_w    = {1'b0, end_q} - {1'b0, start_q} + (TAP_W+1)'(1);
  assign tap_sum  = {1'b0, start_q} + {1'b0, end_q};
  assign center_o = tap_sum[TAP_W:1];
  assign open_o   = found_q & ~closed_q;
  assign valid_o  = found_q && (eye_w >= (TAP_W+1)'(MIN_EYE));

endmodule

// File: rtl/ddr_read_eye_trainer.sv
// Sequential per-lane read-eye sweep: step the IOD delay line through every
// tap, find the first passing window and park each lane at its centre.
//
// state  | meaning
// IDLE   | waiting for train_start_i
// LOAD   | delay-line load pulse on active lane, tap and tracker reset
// CLEAR  | eye-monitor flag clear pulse
// SETTLE | wait SETTLE_CYCLES after clear
// SAMPLE | OR early|late over SAMPLE_CYCLES, update window tracker
// STEP   | increment move pulse then gap cycle checking out-of-range
// CENTER | decrement moves back to window centre, or flag lane error
// NEXT   | advance to next lane or finish
// DONE   | one cycle, busy drops and done rises
module ddr_read_eye_trainer
  import ddr_train_pkg::*;
#(
  parameter int NUM_LANES     = 2,
  parameter int DLY_TAPS      = 128,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_EYE       = 4,
  localparam int TAP_W        = tap_w(DLY_TAPS)
) (
  input  logic                       fab_clk_i,
  input  logic                       arst_n_i,
  input  logic                       train_start_i,
  output logic                       train_busy_o,
  output logic                       train_done_o,
  output logic [NUM_LANES-1:0]       train_err_o,
  output logic [NUM_LANES*TAP_W-1:0] lane_center_o,
  output logic [NUM_LANES-1:0]       delay_line_load_o,
  output logic [NUM_LANES-1:0]       delay_line_move_o,
  output logic [NUM_LANES-1:0]       delay_line_direction_o,
  output logic [NUM_LANES-1:0]       eye_monitor_clear_flags_o,
  input  logic [NUM_LANES-1:0]       eye_monitor_early_i,
  input  logic [NUM_LANES-1:0]       eye_monitor_late_i,
  input  logic [NUM_LANES-1:0]       delay_line_out_of_range_i
);

  localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(DLY_TAPS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  train_state_e state_q, state_d;
  logic [LANE_W-1:0]          lane_q, lane_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [TAP_W-1:0]           cur_tap_q, cur_tap_d;
  logic                       or_q, or_d;
  logic                       phase_q, phase_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [NUM_LANES-1:0]       err_q, err_d;
  logic [NUM_LANES*TAP_W-1:0] center_q, center_d;
  logic [NUM_LANES-1:0]       load_q, load_d;
  logic [NUM_LANES-1:0]       move_q, move_d;
  logic [NUM_LANES-1:0]       dir_q, dir_d;
  logic [NUM_LANES-1:0]       clr_q, clr_d;

  logic [NUM_LANES-1:0] lane_mask, next_mask;
  logic [LANE_W-1:0]    next_lane;
  logic                 flag_now, oor_now, tap_pass, sweep_end, sample_last;
  logic                 trk_open, trk_valid;
  logic [TAP_W-1:0]     trk_center;

  assign next_lane   = lane_q + LANE_W'(1);
  assign lane_mask   = NUM_LANES'(1) << lane_q;
  assign next_mask   = NUM_LANES'(1) << next_lane;
  assign flag_now    = eye_monitor_early_i[lane_q] | eye_monitor_late_i[lane_q];
  assign oor_now     = delay_line_out_of_range_i[lane_q];
  assign sample_last = (state_q == ST_SAMPLE) && (cnt_q == '0);
  assign tap_pass    = ~(or_q | flag_now);
  // A fail only terminates the sweep once a window has been seen.
  assign sweep_end   = (~tap_pass & trk_open) | (cur_tap_q == LAST_TAP);

  ddr_eye_window_tracker #(
    .TAP_W  (TAP_W),
    .MIN_EYE(MIN_EYE)
  ) u_tracker (
    .clk_i   (fab_clk_i),
    .rst_n_i (arst_n_i),
    .clear_i (state_q == ST_LOAD),
    .sample_i(sample_last),
    .pass_i  (tap_pass),
    .tap_i   (cur_tap_q),
    .open_o  (trk_open),
    .valid_o (trk_valid),
    .center_o(trk_center)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    cnt_d     = cnt_q;
    cur_tap_d = cur_tap_q;
    or_d      = or_q;
    phase_d   = phase_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    center_d  = center_q;
    dir_d     = dir_q;
    load_d    = '0;
    move_d    = '0;
    clr_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (train_start_i) begin
          state_d = ST_LOAD;
          lane_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = '0;
          load_d  = NUM_LANES'(1);
          dir_d   = {NUM_LANES{DIR_INC}} & NUM_LANES'(1);
        end
      end
      ST_LOAD: begin
        cur_tap_d = '0;
        clr_d     = lane_mask;
        state_d   = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(SAMPLE_CYCLES - 1);
          or_d    = 1'b0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        or_d = or_q | flag_now;
        if (cnt_q == '0) begin
          if (sweep_end) begin
            dir_d   = {NUM_LANES{DIR_DEC}};
            phase_d = 1'b0;
            state_d = ST_CENTER;
          end else begin
            move_d  = lane_mask;
            phase_d = 1'b1;
            state_d = ST_STEP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STEP: begin
        if (phase_q) begin
          phase_d = 1'b0;
        end else if (oor_now) begin
          // The IOD refused the step: tap stays put and the sweep stops here.
          dir_d   = {NUM_LANES{DIR_DEC}};
          state_d = ST_CENTER;
        end else begin
          cur_tap_d = cur_tap_q + TAP_W'(1);
          clr_d     = lane_mask;
          state_d   = ST_CLEAR;
        end
      end
      ST_CENTER: begin
        if (!trk_valid) begin
          err_d[lane_q] = 1'b1;
          center_d[int'(lane_q)*TAP_W +: TAP_W] = '0;
          load_d  = lane_mask;
          state_d = ST_NEXT;
        end else begin
          center_d[int'(lane_q)*TAP_W +: TAP_W] = trk_center;
          if (phase_q) begin
            phase_d = 1'b0;
          end else if (cur_tap_q != trk_center) begin
            move_d    = lane_mask;
            cur_tap_d = cur_tap_q - TAP_W'(1);
            phase_d   = 1'b1;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (lane_q == LAST_LANE) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          lane_d  = next_lane;
          load_d  = next_mask;
          dir_d   = {NUM_LANES{DIR_INC}} & next_mask;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fab_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= ST_IDLE;
      lane_q    <= '0;
      cnt_q     <= '0;
      cur_tap_q <= '0;
      or_q      <= 1'b0;
      phase_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      center_q  <= '0;
      load_q    <= '0;
      move_q    <= '0;
      dir_q     <= '0;
      clr_q     <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
      cur_tap_q <= cur_tap_d;
      or_q      <= or_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      center_q  <= center_d;
      load_q    <= load_d;
      move_q    <= move_d;
      dir_q     <= dir_d;
      clr_q     <= clr_d;
    end
  end

  assign train_busy_o              = busy_q;
  assign train_done_o              = done_q;
  assign train_err_o               = err_q;
  assign lane_center_o             = center_q;
  assign delay_line_load_o         = load_q;
  assign delay_line_move_o         = move_q;
  assign delay_line_direction_o    = dir_q;
  assign eye_monitor_clear_flags_o = clr_q;

endmodule

// File: tb/tb_ddr_read_eye_trainer.sv
// Directed bench for ddr_read_eye_trainer with a behavioural IOD model per lane
// (tap counter, sticky early/late flags outside [a,b], optional out-of-range tap).
module tb_ddr_read_eye_trainer;
  localparam int NL   = 2;
  localparam int TAPS = 16;
  localparam int TW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic [NL-1:0] err, load, move, dir, clear;
  logic [NL*TW-1:0] center;
  logic [NL-1:0] flag_e = '0;
  logic [NL-1:0] flag_l = '0;
  logic [NL-1:0] oor = '0;

  always #5 clk = ~clk;

  ddr_read_eye_trainer #(
    .NUM_LANES(NL), .DLY_TAPS(TAPS), .SETTLE_CYCLES(2), .SAMPLE_CYCLES(4), .MIN_EYE(4)
  ) dut (
    .fab_clk_i                (clk),
    .arst_n_i                 (rst_n),
    .train_start_i            (start),
    .train_busy_o             (busy),
    .train_done_o             (done),
    .train_err_o              (err),
    .lane_center_o            (center),
    .delay_line_load_o        (load),
    .delay_line_move_o        (move),
    .delay_line_direction_o   (dir),
    .eye_monitor_clear_flags_o(clear),
    .eye_monitor_early_i      (flag_e),
    .eye_monitor_late_i       (flag_l),
    .delay_line_out_of_range_i(oor)
  );

  int tap[NL] = '{0, 0};
  int win_a[NL] = '{0, 0};
  int win_b[NL] = '{15, 15};
  int oor_tap[NL] = '{-1, -1};
  int inc_cnt[NL] = '{0, 0};
  int dec_cnt[NL] = '{0, 0};
  int load_cnt[NL] = '{0, 0};
  int dir_viol = 0;
  int cyc = 0;
  int clr_n = 0;
  int clr_t0 = 0;
  int clr_t1 = 0;
  logic cnt_clr = 1'b0;
  logic [NL-1:0] dir_prev = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    dir_prev <= dir;
    for (int l = 0; l < NL; l++) begin
      oor[l] <= 1'b0;
      if (load[l]) tap[l] <= 0;
      else if (move[l]) begin
        if (dir[l] !== dir_prev[l]) dir_viol <= dir_viol + 1;
        if (dir[l]) begin
          if (tap[l] == oor_tap[l]) oor[l] <= 1'b1;
          else tap[l] <= tap[l] + 1;
        end else tap[l] <= tap[l] - 1;
      end
      if (clear[l]) begin
        flag_e[l] <= 1'b0;
        flag_l[l] <= 1'b0;
      end else begin
        if (tap[l] < win_a[l]) flag_e[l] <= 1'b1;
        if (tap[l] > win_b[l]) flag_l[l] <= 1'b1;
      end
      if (cnt_clr) begin
        inc_cnt[l] <= 0;
        dec_cnt[l] <= 0;
        load_cnt[l] <= 0;
      end else begin
        if (move[l] && dir[l]) inc_cnt[l] <= inc_cnt[l] + 1;
        if (move[l] && !dir[l]) dec_cnt[l] <= dec_cnt[l] + 1;
        if (load[l]) load_cnt[l] <= load_cnt[l] + 1;
      end
    end
    if (cnt_clr) clr_n <= 0;
    else if (clear[0]) begin
      if (clr_n == 0) clr_t0 <= cyc;
      if (clr_n == 1) clr_t1 <= cyc;
      clr_n <= clr_n + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    @(negedge clk) cnt_clr = 1'b1;
    @(negedge clk) cnt_clr = 1'b0;
  endtask

  task automatic set_win(input int l, input int a, input int b);
    win_a[l] = a;
    win_b[l] = b;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input string tag);
    clear_counts();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(tag);
  endtask

  task automatic check_nominal(input string tag);
    chk({tag, "_inc0"}, inc_cnt[0], 12);
    chk({tag, "_dec0"}, dec_cnt[0], 4);
    chk({tag, "_ctr0"}, {28'd0, center[3:0]}, 8);
    chk({tag, "_inc1"}, inc_cnt[1], 15);
    chk({tag, "_dec1"}, dec_cnt[1], 8);
    chk({tag, "_ctr1"}, {28'd0, center[7:4]}, 7);
    chk({tag, "_err"}, {30'd0, err}, 0);
    chk({tag, "_tap0"}, tap[0], 8);
    chk({tag, "_tap1"}, tap[1], 7);
    chk({tag, "_load0"}, load_cnt[0], 1);
    chk({tag, "_load1"}, load_cnt[1], 1);
  endtask

  initial begin
    int n;
    int snap;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {30'd0, err}, 0);
    chk("rst_center", {24'd0, center}, 0);
    chk("rst_pulses", {24'd0, load, move, dir, clear}, 0);
    rst_n = 1'b1;

    // Nominal run with start-latency check: lane0 [5,11], lane1 [0,15]
    set_win(0, 5, 11);
    set_win(1, 0, 15);
    clear_counts();
    @(negedge clk) start = 1'b1;
    chk("start_busy_before", {31'd0, busy}, 0);
    @(posedge clk) #1;
    chk("start_busy_after", {31'd0, busy}, 1);
    chk("start_load", {30'd0, load}, 2'b01);
    @(negedge clk) start = 1'b0;
    wait_done("nom");
    check_nominal("nom");
    chk("tap_spacing", clr_t1 - clr_t0, 9);

    // Lane0 never passes
    set_win(0, 99, -1);
    run("nopass");
    chk("nopass_err", {30'd0, err}, 2'b01);
    chk("nopass_ctr0", {28'd0, center[3:0]}, 0);
    chk("nopass_load0", load_cnt[0], 2);
    chk("nopass_tap0", tap[0], 0);
    chk("nopass_ctr1", {28'd0, center[7:4]}, 7);

    // Lane0 eye too narrow: [6,8]
    set_win(0, 6, 8);
    run("narrow");
    chk("narrow_err", {30'd0, err}, 2'b01);
    chk("narrow_ctr0", {28'd0, center[3:0]}, 0);
    chk("narrow_inc0", inc_cnt[0], 9);

    // Out-of-range on the step from tap 9
    set_win(0, 6, 15);
    oor_tap[0] = 9;
    run("oor");
    oor_tap[0] = -1;
    chk("oor_err", {30'd0, err}, 0);
    chk("oor_ctr0", {28'd0, center[3:0]}, 7);
    chk("oor_dec0", dec_cnt[0], 2);
    chk("oor_tap0", tap[0], 7);

    // Start pulse while busy is ignored
    set_win(0, 5, 11);
    clear_counts();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (60) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("ign_busy", {31'd0, busy}, 1);
    wait_done("ign");
    check_nominal("ign");

    // Reset in the middle of SAMPLE
    clear_counts();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!clear[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_clear_seen", {31'd0, clear[0]}, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 0);
    chk("rstmid_dir", {30'd0, dir}, 0);
    chk("rstmid_outs", {23'd0, done, load, move, clear, err}, 0);
    chk("rstmid_center", {24'd0, center}, 0);
    snap = inc_cnt[0] + dec_cnt[0] + load_cnt[0] + load_cnt[1];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_quiet", inc_cnt[0] + dec_cnt[0] + load_cnt[0] + load_cnt[1], snap);
    chk("rstmid_idle_busy", {31'd0, busy}, 0);
    run("retrain");
    check_nominal("retrain");

    chk("dir_stable", dir_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
